pipe_stage_elastic: RTL
=======================

Name: pipe_stage_elastic

Overview:
- Parametrised successor to the fixed MEM/WB-style pipeline latch.
- DEPTH-deep chain of register slots carrying a control field and a data field. Each slot has a valid bit and a valid/ready handshake.
- Adds backpressure (stall), bubble collapsing and flush. Control bits are cleared on flush, so squashed instructions cannot write the register file.
- Sits between any two processor stages, e.g. MEM->WB, or an EX->MEM pair for multi-cycle units.

Parameters:
- DATA_W, 69, width of the data payload (two 32-bit words plus 5-bit register index).
- CTRL_W, 2, width of the control payload (e.g. RegWrite, MemtoReg); cleared on flush.
- DEPTH, 1, number of register slots; legal range 1..8.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high reset.
- Flush  in  1  squash all slots.
- In_valid  in  1  upstream has a beat.
- In_ready  out  1  block accepts the beat this cycle.
- In_ctrl  in  CTRL_W  upstream control bits.
- In_data  in  DATA_W  upstream data.
- Out_valid  out  1  slot DEPTH-1 holds a beat.
- Out_ready  in  1  downstream accepts.
- Out_ctrl  out  CTRL_W  control field of slot DEPTH-1.
- Out_data  out  DATA_W  data field of slot DEPTH-1.
- Occupancy  out  $clog2(DEPTH+1)  count of valid slots.

Behaviour:
- Reset (async, active-high): all valid bits, ctrl and data registers go to 0. Out_valid=0, Out_ctrl=0, Out_data=0, Occupancy=0, Stall_count=0.
- Slot i (0..DEPTH-1) holds valid[i], ctrl[i] and data[i]. Slot DEPTH-1 drives the outputs directly from registers; there is no combinational path from In_* to Out_*.
- adv[DEPTH] = Out_ready.
- adv[i] = valid[i] && (!valid[i+1] || adv[i+1]); slot DEPTH-1 uses Out_ready as its downstream term.
- Slot i loads from slot i-1 (or from In_* for i=0) when it is empty or advancing. Otherwise it holds.
- In_ready = !Flush && (!valid[0] || adv[0]). This is a combinational chain from Out_ready; this is accepted at DEPTH<=8.
- Transfer at the input occurs when In_valid && In_ready. Transfer at the output occurs when Out_valid && Out_ready.
- Latency with no backpressure is DEPTH cycles. Throughput is 1 beat/cycle.
- Bubbles collapse: an empty slot is filled even while the output is stalled.
- Data and ctrl of an empty slot are don't-care for the data field. The ctrl field of an empty slot is 0.
- Flush (synchronous, priority over all loads):
  - Next cycle every valid and every ctrl register is 0.
  - Data registers hold their values.
  - An output transfer in the Flush cycle still completes (downstream consumed it).
  - In_ready=0, so no input is accepted.
- Simultaneous input and output transfer with all slots full: legal, Occupancy unchanged.
- Occupancy is a registered counter: +1 on input transfer, -1 on output transfer, unchanged when both occur, 0 on Flush.
- DEPTH outside 1..8: elaboration error.

Optional Feature:
- Macro PIPE_STAGE_STALL_CNT_EN.
- Defined: adds output port Stall_count (32 bits), reset to 0.
  - Increments each cycle Out_valid && !Out_ready && !Flush.
  - Saturates at 32'hFFFF_FFFF; cleared only by Reset.
- Undefined: the port and counter do not exist; behaviour is otherwise identical.

Decomposition:
- Package pipe_stage_pkg holds:
  - DEPTH_MAX=8;
  - default widths (WORD=32, RWIDTH=5);
  - ctrl bit indices CTRL_REGWRITE=0 and CTRL_MEMTOREG=1;
  - the function for Occupancy width.
- One sub-module, pipe_stage_slot: a single valid/ctrl/data register with load, hold and clear inputs. It is instantiated DEPTH times via generate.

Test Plan:
- Reset with DEPTH=3: assert Reset mid-stream with 3 valid beats -> same-cycle Out_valid=0, Out_ctrl=0, Occupancy=0; after release In_ready=1.
- Streaming with DEPTH=3, Out_ready=1: beats 0x01..0x05, one per cycle -> each appears on Out_data exactly 3 cycles after acceptance, in order, no gaps.
- Backpressure with DEPTH=2: hold Out_ready=0, push 3 beats -> first 2 accepted, In_ready=0 on 3rd, Occupancy=2. Raise Out_ready -> 3rd accepted the same cycle, order preserved.
- Bubble collapse with DEPTH=3: push beat A, idle 1 cycle, push B, with Out_ready=0 -> A and B end in slots 2 and 1, Occupancy=2, no empty slot between them.
- Flush with DEPTH=3 full, ctrl=2'b11, In_valid=1 and Out_ready=1 in the Flush cycle -> the output beat is consumed, the input is not accepted, next cycle Occupancy=0 and Out_ctrl=0.
- With PIPE_STAGE_STALL_CNT_EN defined: 10 cycles of Out_valid=1, Out_ready=0 -> Stall_count=10. Preload near saturation -> holds at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/pipe_stage_pkg.sv
// Shared constants for the elastic pipeline stage: default payload widths,
// control-bit positions and the occupancy-counter width helper.
package pipe_stage_pkg;

    localparam int DEPTH_MAX     = 8;
    localparam int WORD          = 32;
    localparam int RWIDTH        = 5;
    localparam int DATA_W_DEF    = 2 * WORD + RWIDTH;
    localparam int CTRL_W_DEF    = 2;

    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMTOREG = 1;

    // Wide enough to count 0..depth inclusive.
    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_stage_slot.sv
// One register slot of the elastic stage: valid, control and data.
// Clear drops valid/ctrl but leaves data untouched.
module pipe_stage_slot
    import pipe_stage_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic              i_valid,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;

    // An empty slot always carries zero ctrl so it can never trigger a write.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (i_load) begin
            r_valid <= i_valid;
            r_ctrl  <= i_valid ? i_ctrl : '0;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_ctrl  = r_ctrl;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_elastic.sv
// DEPTH-slot elastic pipeline latch with backpressure, bubble collapse and flush.
// Optional PIPE_STAGE_STALL_CNT_EN adds a saturating output-stall counter.
module pipe_stage_elastic
    import pipe_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DEPTH  = 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_flush,
    input  logic                      i_in_valid,
    output logic                      o_in_ready,
    input  logic [CTRL_W-1:0]         i_in_ctrl,
    input  logic [DATA_W-1:0]         i_in_data,
    output logic                      o_out_valid,
    input  logic                      i_out_ready,
    output logic [CTRL_W-1:0]         o_out_ctrl,
    output logic [DATA_W-1:0]         o_out_data,
    output logic [occ_w(DEPTH)-1:0]   o_occupancy
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    output logic [31:0]               o_stall_count
`endif
);

    localparam int OCC_W = occ_w(DEPTH);

    if (DEPTH < 1 || DEPTH > DEPTH_MAX) begin : g_bad_depth
        $error("pipe_stage_elastic: DEPTH must be in 1..%0d", DEPTH_MAX);
    end

    logic [DEPTH-1:0]             w_vld;
    logic [DEPTH-1:0][CTRL_W-1:0] w_ctrl;
    logic [DEPTH-1:0][DATA_W-1:0] w_data;
    logic [DEPTH:0]               w_full;
    logic [DEPTH:0]               w_adv;
    logic [DEPTH-1:0]             w_load;
    logic                         w_in_xfer;
    logic                         w_out_xfer;
    logic [OCC_W-1:0]             r_occ;

    // Treat the position past the last slot as always occupied so the tail
    // slot advances purely on downstream ready.
    always_comb begin
        w_full       = {1'b1, w_vld};
        w_adv        = '0;
        w_adv[DEPTH] = i_out_ready;
        for (int i = DEPTH - 1; i >= 0; i--)
            w_adv[i] = w_vld[i] && (!w_full[i+1] || w_adv[i+1]);
    end

    assign w_load     = ~w_vld | w_adv[DEPTH-1:0];
    assign o_in_ready = !i_flush && w_load[0];
    assign w_in_xfer  = i_in_valid && o_in_ready;
    assign w_out_xfer = o_out_valid && i_out_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic              w_src_vld;
        logic [CTRL_W-1:0] w_src_ctrl;
        logic [DATA_W-1:0] w_src_data;

        if (i == 0) begin : g_head
            assign w_src_vld  = w_in_xfer;
            assign w_src_ctrl = i_in_ctrl;
            assign w_src_data = i_in_data;
        end else begin : g_body
            assign w_src_vld  = w_vld[i-1];
            assign w_src_ctrl = w_ctrl[i-1];
            assign w_src_data = w_data[i-1];
        end

        pipe_stage_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_slot (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_load  (w_load[i]),
            .i_clear (i_flush),
            .i_valid (w_src_vld),
            .i_ctrl  (w_src_ctrl),
            .i_data  (w_src_data),
            .o_valid (w_vld[i]),
            .o_ctrl  (w_ctrl[i]),
            .o_data  (w_data[i])
        );
    end

    assign o_out_valid = w_vld[DEPTH-1];
    assign o_out_ctrl  = w_ctrl[DEPTH-1];
    assign o_out_data  = w_data[DEPTH-1];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_occ <= '0;
        else if (i_flush)
            r_occ <= '0;
        else if (w_in_xfer && !w_out_xfer)
            r_occ <= r_occ + OCC_W'(1);
        else if (!w_in_xfer && w_out_xfer)
            r_occ <= r_occ - OCC_W'(1);
    end

    assign o_occupancy = r_occ;

`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [31:0] r_stall;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_stall <= '0;
        else if (o_out_valid && !i_out_ready && !i_flush && r_stall != 32'hFFFF_FFFF)
            r_stall <= r_stall + 32'd1;
    end

    assign o_stall_count = r_stall;
`endif

endmodule
